// File: rtl/eth_font_pkg.sv
// Shared constants, state encoding and byte classifiers for the UDP-payload
// to font-glyph SD address generator.
package eth_font_pkg;

   localparam logic [31:0] AsciiBaseDef = 32'd12_713_984;
   localparam logic [31:0] GbkBaseDef   = 32'd12_779_520;

   // Bytes per glyph expressed as shift amounts (256 and 512 bytes).
   localparam int unsigned AsciiShift = 8;
   localparam int unsigned GbkShift   = 9;

   localparam logic [7:0] GbkLeadMin   = 8'h81;
   localparam logic [7:0] GbkLeadMax   = 8'hFE;
   localparam logic [7:0] GbkTrailMin  = 8'h40;
   localparam logic [7:0] GbkTrailMax  = 8'hFE;
   localparam logic [7:0] GbkTrailHole = 8'h7F;
   localparam logic [7:0] GbkTrailHi   = 8'h80;
   localparam logic [14:0] GbkRowLen   = 15'd190;

   typedef enum logic {
      StLead  = 1'b0,
      StTrail = 1'b1
   } font_state_e;

   function automatic logic is_gbk_lead(input logic [7:0] b);
      return (b >= GbkLeadMin) && (b <= GbkLeadMax);
   endfunction

   function automatic logic is_gbk_trail(input logic [7:0] b);
      return (b >= GbkTrailMin) && (b <= GbkTrailMax) && (b != GbkTrailHole);
   endfunction

endpackage

// File: rtl/eth_font_addr_calc.sv
// Combinational glyph address: ASCII uses lead as the character byte,
// GBK folds the lead/trail pair into a 15-bit table index.
module eth_font_addr_calc
   import eth_font_pkg::*;
#(
   parameter logic [31:0] ASCII_BASE = AsciiBaseDef,
   parameter logic [31:0] GBK_BASE   = GbkBaseDef
) (
   input  logic [7:0]  lead,
   input  logic [7:0]  trail,
   input  logic        is_gbk,
   output logic [31:0] addr
);

   logic [14:0] row;
   logic [14:0] col;
   logic [14:0] idx;

   always_comb begin
      row = 15'(lead - GbkLeadMin);
      // Trail codes skip 0x7F, so the upper half sits one slot lower.
      col = 15'(trail - GbkTrailMin) - 15'(trail >= GbkTrailHi);
      idx = row * GbkRowLen + col;
      if (is_gbk) begin
         addr = ({17'd0, idx} << GbkShift) + GBK_BASE;
      end else begin
         addr = ({24'd0, lead} << AsciiShift) + ASCII_BASE;
      end
   end

endmodule

// File: rtl/eth_font_addr_gen.sv
// Converts a UDP payload byte stream (ASCII/GBK) into a per-glyph SD address
// stream with a one-entry output register, frame glyph count and error pulses.
module eth_font_addr_gen
   import eth_font_pkg::*;
#(
   parameter logic [31:0] ASCII_BASE = AsciiBaseDef,
   parameter logic [31:0] GBK_BASE   = GbkBaseDef,
   parameter int unsigned MAX_FONTS  = 60
) (
   input  logic        rgmii_clk,
   input  logic        rstn,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   input  logic        in_last,
   output logic        in_ready,
   output logic        out_valid,
   output logic [31:0] out_addr,
   output logic        out_is_gbk,
   input  logic        out_ready,
   output logic [6:0]  font_count,
   output logic        frame_done,
   output logic        err_orphan,
   output logic        err_invalid,
   output logic        err_overflow
);

   localparam logic [6:0] MaxCnt = 7'(MAX_FONTS);

   font_state_e state_q, state_d;
   logic [7:0]  lead_q, lead_d;
   logic [6:0]  cnt_q, cnt_d;
   logic [6:0]  font_count_q, font_count_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_addr_q, out_addr_d;
   logic        out_is_gbk_q, out_is_gbk_d;
   logic        frame_done_q, frame_done_d;
   logic        err_orphan_q, err_orphan_d;
   logic        err_invalid_q, err_invalid_d;
   logic        err_overflow_q, err_overflow_d;

   logic        accept;
   logic        glyph;
   logic        glyph_gbk;
   logic        cnt_inc;
   logic [31:0] calc_addr;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   eth_font_addr_calc #(
      .ASCII_BASE (ASCII_BASE),
      .GBK_BASE   (GBK_BASE)
   ) u_calc (
      .lead   ((state_q == StTrail) ? lead_q : in_data),
      .trail  (in_data),
      .is_gbk (state_q == StTrail),
      .addr   (calc_addr)
   );

   always_comb begin
      state_d        = state_q;
      lead_d         = lead_q;
      cnt_d          = cnt_q;
      font_count_d   = font_count_q;
      out_valid_d    = out_valid_q && !out_ready;
      out_addr_d     = out_addr_q;
      out_is_gbk_d   = out_is_gbk_q;
      frame_done_d   = 1'b0;
      err_orphan_d   = 1'b0;
      err_invalid_d  = 1'b0;
      err_overflow_d = 1'b0;
      glyph          = 1'b0;
      glyph_gbk      = 1'b0;
      cnt_inc        = 1'b0;

      if (accept) begin
         unique case (state_q)
            StLead: begin
               if (in_data < 8'h80) begin
                  glyph = 1'b1;
               end else if (is_gbk_lead(in_data)) begin
                  if (in_last) begin
                     err_orphan_d = 1'b1;
                  end else begin
                     state_d = StTrail;
                     lead_d  = in_data;
                  end
               end else begin
                  err_invalid_d = 1'b1;
               end
            end
            StTrail: begin
               state_d = StLead;
               if (is_gbk_trail(in_data)) begin
                  glyph     = 1'b1;
                  glyph_gbk = 1'b1;
               end else begin
                  err_invalid_d = 1'b1;
               end
            end
            default: state_d = StLead;
         endcase

         cnt_inc = glyph && (cnt_q < MaxCnt);
         if (glyph && !cnt_inc) begin
            err_overflow_d = 1'b1;
         end
         if (cnt_inc) begin
            out_valid_d  = 1'b1;
            out_addr_d   = calc_addr;
            out_is_gbk_d = glyph_gbk;
         end

         if (in_last) begin
            frame_done_d = 1'b1;
            font_count_d = cnt_q + 7'(cnt_inc);
            cnt_d        = 7'd0;
            state_d      = StLead;
         end else begin
            cnt_d = cnt_q + 7'(cnt_inc);
         end
      end
   end

   always_ff @(posedge rgmii_clk) begin
      if (!rstn) begin
         state_q        <= StLead;
         lead_q         <= 8'd0;
         cnt_q          <= 7'd0;
         font_count_q   <= 7'd0;
         out_valid_q    <= 1'b0;
         out_addr_q     <= 32'd0;
         out_is_gbk_q   <= 1'b0;
         frame_done_q   <= 1'b0;
         err_orphan_q   <= 1'b0;
         err_invalid_q  <= 1'b0;
         err_overflow_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         lead_q         <= lead_d;
         cnt_q          <= cnt_d;
         font_count_q   <= font_count_d;
         out_valid_q    <= out_valid_d;
         out_addr_q     <= out_addr_d;
         out_is_gbk_q   <= out_is_gbk_d;
         frame_done_q   <= frame_done_d;
         err_orphan_q   <= err_orphan_d;
         err_invalid_q  <= err_invalid_d;
         err_overflow_q <= err_overflow_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_addr     = out_addr_q;
   assign out_is_gbk   = out_is_gbk_q;
   assign font_count   = font_count_q;
   assign frame_done   = frame_done_q;
   assign err_orphan   = err_orphan_q;
   assign err_invalid  = err_invalid_q;
   assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_eth_font_addr_gen.sv
// Directed bench for eth_font_addr_gen: inputs change on the falling edge,
// outputs are sampled on the following falling edge.
module tb_eth_font_addr_gen;

   logic        rgmii_clk = 1'b0;
   logic        rstn;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_last;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_addr;
   logic        out_is_gbk;
   logic        out_ready;
   logic [6:0]  font_count;
   logic        frame_done;
   logic        err_orphan;
   logic        err_invalid;
   logic        err_overflow;

   int checks   = 0;
   int failures = 0;
   int n_glyph;
   int n_ovf;

   always #5 rgmii_clk = ~rgmii_clk;

   eth_font_addr_gen dut (
      .rgmii_clk    (rgmii_clk),
      .rstn         (rstn),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_last      (in_last),
      .in_ready     (in_ready),
      .out_valid    (out_valid),
      .out_addr     (out_addr),
      .out_is_gbk   (out_is_gbk),
      .out_ready    (out_ready),
      .font_count   (font_count),
      .frame_done   (frame_done),
      .err_orphan   (err_orphan),
      .err_invalid  (err_invalid),
      .err_overflow (err_overflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge rgmii_clk);
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic l);
      in_valid = v;
      in_data  = d;
      in_last  = l;
   endtask

   initial begin
      rstn      = 1'b0;
      out_ready = 1'b1;
      drive(1'b0, 8'h00, 1'b0);
      repeat (2) step();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_addr", out_addr, 32'd0);
      chk("rst_is_gbk", 32'(out_is_gbk), 32'd0);
      chk("rst_font_count", 32'(font_count), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      chk("rst_errs", {29'd0, err_orphan, err_invalid, err_overflow}, 32'd0);
      rstn = 1'b1;
      step();
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // Single ASCII 'A' frame.
      drive(1'b1, 8'h41, 1'b1);
      step();
      chk("a_valid", 32'(out_valid), 32'd1);
      chk("a_addr", out_addr, 32'd12_730_624);
      chk("a_gbk", 32'(out_is_gbk), 32'd0);
      chk("a_done", 32'(frame_done), 32'd1);
      chk("a_count", 32'(font_count), 32'd1);
      drive(1'b0, 8'h00, 1'b0);
      step();
      chk("a_valid_drop", 32'(out_valid), 32'd0);
      chk("a_done_pulse", 32'(frame_done), 32'd0);
      chk("a_count_hold", 32'(font_count), 32'd1);

      // GBK pair B0 A1.
      drive(1'b1, 8'hB0, 1'b0);
      step();
      chk("g_lead_noout", 32'(out_valid), 32'd0);
      drive(1'b1, 8'hA1, 1'b1);
      step();
      chk("g_valid", 32'(out_valid), 32'd1);
      chk("g_addr", out_addr, 32'd17_400_832);
      chk("g_gbk", 32'(out_is_gbk), 32'd1);
      chk("g_done", 32'(frame_done), 32'd1);
      chk("g_count", 32'(font_count), 32'd1);
      drive(1'b0, 8'h00, 1'b0);
      step();

      // Backpressure: 'A' held three cycles while 'B' waits.
      out_ready = 1'b0;
      drive(1'b1, 8'h41, 1'b0);
      step();
      drive(1'b1, 8'h42, 1'b1);
      for (int i = 0; i < 3; i++) begin
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_addr", out_addr, 32'd12_730_624);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_no_done", 32'(frame_done), 32'd0);
         if (i < 2) step();
      end
      out_ready = 1'b1;
      step();
      chk("bp_b_valid", 32'(out_valid), 32'd1);
      chk("bp_b_addr", out_addr, 32'd12_730_880);
      chk("bp_b_done", 32'(frame_done), 32'd1);
      chk("bp_count", 32'(font_count), 32'd2);
      drive(1'b0, 8'h00, 1'b0);
      step();
      chk("bp_drain", 32'(out_valid), 32'd0);

      // Orphan lead with in_last.
      drive(1'b1, 8'hB0, 1'b1);
      step();
      chk("orph_err", 32'(err_orphan), 32'd1);
      chk("orph_noout", 32'(out_valid), 32'd0);
      chk("orph_done", 32'(frame_done), 32'd1);
      chk("orph_count", 32'(font_count), 32'd0);
      drive(1'b0, 8'h00, 1'b0);
      step();
      chk("orph_pulse", 32'(err_orphan), 32'd0);

      // Invalid lead, then a pair with the 0x7F hole as trail.
      drive(1'b1, 8'h80, 1'b0);
      step();
      chk("inv_lead_err", 32'(err_invalid), 32'd1);
      chk("inv_lead_noout", 32'(out_valid), 32'd0);
      drive(1'b1, 8'hB0, 1'b0);
      step();
      chk("inv_lead_pulse", 32'(err_invalid), 32'd0);
      drive(1'b1, 8'h7F, 1'b1);
      step();
      chk("inv_trail_err", 32'(err_invalid), 32'd1);
      chk("inv_trail_noout", 32'(out_valid), 32'd0);
      chk("inv_trail_count", 32'(font_count), 32'd0);

      // GBK index boundaries: first glyph, first upper-half trail, last glyph.
      drive(1'b1, 8'h81, 1'b0);
      step();
      drive(1'b1, 8'h40, 1'b0);
      step();
      chk("gmin_addr", out_addr, 32'd12_779_520);
      drive(1'b1, 8'h81, 1'b0);
      step();
      drive(1'b1, 8'h80, 1'b0);
      step();
      chk("ghi_addr", out_addr, 32'd12_811_776);
      drive(1'b1, 8'hFE, 1'b0);
      step();
      drive(1'b1, 8'hFE, 1'b1);
      step();
      chk("gmax_addr", out_addr, 32'd25_036_288);
      chk("gmax_gbk", 32'(out_is_gbk), 32'd1);
      chk("gbnd_count", 32'(font_count), 32'd3);
      drive(1'b0, 8'h00, 1'b0);
      step();

      // 61 ASCII bytes: the last one overflows.
      n_glyph = 0;
      n_ovf   = 0;
      for (int i = 0; i < 61; i++) begin
         drive(1'b1, 8'h30, (i == 60));
         step();
         if (out_valid) n_glyph++;
         if (err_overflow) n_ovf++;
      end
      chk("ovf_done", 32'(frame_done), 32'd1);
      chk("ovf_count", 32'(font_count), 32'd60);
      drive(1'b0, 8'h00, 1'b0);
      step();
      if (err_overflow) n_ovf++;
      chk("ovf_glyphs", n_glyph, 32'd60);
      chk("ovf_pulses", n_ovf, 32'd1);

      // Reset mid-pair discards the stored lead.
      drive(1'b1, 8'hB0, 1'b0);
      step();
      drive(1'b0, 8'h00, 1'b0);
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      chk("mr_in_ready", 32'(in_ready), 32'd1);
      chk("mr_count_clr", 32'(font_count), 32'd0);
      drive(1'b1, 8'h41, 1'b1);
      step();
      chk("mr_valid", 32'(out_valid), 32'd1);
      chk("mr_addr", out_addr, 32'd12_730_624);
      chk("mr_gbk", 32'(out_is_gbk), 32'd0);
      chk("mr_errs", {29'd0, err_orphan, err_invalid, err_overflow}, 32'd0);
      chk("mr_count", 32'(font_count), 32'd1);
      drive(1'b0, 8'h00, 1'b0);

      // Idle bus: no frame_done without beats.
      for (int i = 0; i < 3; i++) begin
         step();
         chk("idle_no_done", 32'(frame_done), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/eth_font_addr_gen.md
ETH_FONT_ADDR_GEN -- requirements
Module: eth_font_addr_gen

Interface
REQ-001 SHALL have parameter ASCII_BASE, default 32'd12_713_984, meaning SD byte address of ASCII font table.
REQ-002 SHALL have parameter GBK_BASE, default 32'd12_779_520, meaning SD byte address of GBK font table.
REQ-003 SHALL have parameter MAX_FONTS, default 60, meaning maximum glyphs emitted per frame.
REQ-004 SHALL have ports rgmii_clk in 1, clock; rstn in 1, reset (synchronous, active-low; clock rgmii_clk).
REQ-005 SHALL have ports in_valid in 1, in_data in 8, in_last in 1, in_ready out 1: UDP payload byte stream, in_last marks final payload byte.
REQ-006 SHALL have ports out_valid out 1, out_addr out 32, out_is_gbk out 1, out_ready in 1: per-glyph SD address stream.
REQ-007 SHALL have ports font_count out 7, frame_done out 1, err_orphan out 1, err_invalid out 1, err_overflow out 1.

Function
REQ-008 SHALL accept a byte when in_valid && in_ready; in_ready = !out_valid || out_ready (one-entry output register, full throughput).
REQ-009 SHALL run FSM LEAD/TRAIL: LEAD classifies each byte; TRAIL holds a stored GBK lead byte awaiting its trail.
REQ-010 In LEAD, byte < 8'h80 SHALL produce out_addr = byte*256 + ASCII_BASE, out_is_gbk=0, out_valid the next cycle (latency 1).
REQ-011 In LEAD, byte 8'h81..8'hFE SHALL be stored and move FSM to TRAIL with no output; byte 8'h80 or 8'hFF SHALL be dropped with err_invalid pulsed one cycle.
REQ-012 In TRAIL, trail 8'h40..8'hFE except 8'h7F SHALL produce out_addr = ((lead-8'h81)*190 + (trail-8'h40) - (trail>=8'h80)) * 512 + GBK_BASE, out_is_gbk=1, latency 1, FSM to LEAD.
REQ-013 In TRAIL, an out-of-range trail SHALL drop the pair, pulse err_invalid, return to LEAD.
REQ-014 Index arithmetic SHALL be 15-bit unsigned (max 23 939), shifted left 9 and added in 32 bits; no truncation.
REQ-015 out_addr/out_is_gbk SHALL remain stable while out_valid && !out_ready.
REQ-016 Glyph counter SHALL increment per emitted glyph and saturate at MAX_FONTS; further glyphs in the frame SHALL be dropped and err_overflow pulsed once per dropped glyph.
REQ-017 Accepting in_last SHALL pulse frame_done one cycle later (same cycle as that byte's out_valid rise, if any), load font_count with the frame glyph count, clear the internal counter, force FSM to LEAD.
REQ-018 in_last accepted in LEAD on a valid lead byte, or with the FSM entering TRAIL, SHALL pulse err_orphan, discard the lead, emit nothing.
REQ-019 font_count SHALL hold its value until the next frame_done.
REQ-020 A zero-length frame (no beats) SHALL produce no frame_done.

Reset
REQ-021 On rstn=0 at a rgmii_clk edge: out_valid=0, out_addr=0, out_is_gbk=0, font_count=0, frame_done=0, all err_* =0, FSM=LEAD, counters cleared.
REQ-022 Reset mid-frame SHALL discard any stored lead byte and any un-consumed output; in_ready SHALL be 1 in the cycle after reset release.

Structure
REQ-023 ASCII_BASE/GBK_BASE defaults, bytes-per-font (256, 512), GBK lead/trail range limits and the FSM state encoding SHALL live in shared package eth_font_pkg.
REQ-024 Address arithmetic SHALL be one combinational sub-module eth_font_addr_calc (inputs lead, trail, is_gbk; output 32-bit address).

Verification
REQ-025 Byte 8'h41 with in_last, out_ready=1 -> next cycle out_valid=1, out_addr=12_730_624, out_is_gbk=0, frame_done=1, font_count=1.
REQ-026 Bytes 8'hB0, 8'hA1 (in_last on second) -> single glyph out_addr=17_400_832, out_is_gbk=1, font_count=1.
REQ-027 'A' then 'B' with out_ready low 3 cycles -> out_addr=12_730_624 held 3 cycles, in_ready=0, no byte lost; 'B' emitted at 12_730_880.
REQ-028 Byte 8'hB0 with in_last -> err_orphan=1 one cycle, no out_valid, frame_done=1, font_count=0.
REQ-029 61 ASCII bytes back-to-back -> exactly 60 outputs, err_overflow pulsed once, font_count=60.
REQ-030 8'hB0 then rstn low 1 cycle, then 8'h41 with in_last -> only ASCII glyph 12_730_624, no GBK output, no errors.
